// File: rtl/present_sbox_sequencer.sv
// One PRESENT round (key add, sLayer, pLayer) that sends the state through an
// external pipelined sbox one nibble per cycle and collects the results into a single 64-bit output.
module present_sbox_sequencer #(
  parameter int          SBOX_LAT  = 3,
  parameter logic [20:0] LFSR_SEED = 21'h1B5E3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_state,
  input  logic [63:0] in_key,
  output logic        sb_x0,
  output logic        sb_x1,
  output logic        sb_x2,
  output logic        sb_x3,
  output logic [20:0] sb_r,
  input  logic        sb_y0,
  input  logic        sb_y1,
  input  logic        sb_y2,
  input  logic        sb_y3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_state
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t      r_state, w_state_next;
  logic [63:0] r_data, r_result, r_out;
  logic [3:0]  r_cnt, r_x;
  logic [20:0] r_lfsr;
  logic [SBOX_LAT-1:0] r_dl_valid;
  logic [3:0]  r_dl_idx [SBOX_LAT];

  logic [63:0] w_in_x, w_result_next;
  logic [3:0]  w_cnt_inc, w_y, w_tail_idx;
  logic        w_tail_valid;

  assign w_in_x       = in_state ^ in_key;
  assign w_cnt_inc    = r_cnt + 4'd1;
  assign w_y          = {sb_y3, sb_y2, sb_y1, sb_y0};
  assign w_tail_valid = r_dl_valid[SBOX_LAT-1];
  assign w_tail_idx   = r_dl_idx[SBOX_LAT-1];

  function automatic logic [63:0] p_layer(input logic [63:0] x);
    logic [63:0] p;
    p     = '0;
    for (int i = 0; i < 63; i++) p[(16 * i) % 63] = x[i];
    p[63] = x[63];
    return p;
  endfunction

  // NOTE: every signal assigned in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_result_next = r_result;
    if (w_tail_valid) w_result_next[{w_tail_idx, 2'b00} +: 4] = w_y;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid) w_state_next = S_ISSUE;
      S_ISSUE: if (r_cnt == 4'd15) w_state_next = S_DRAIN;
      S_DRAIN: if (w_tail_valid && w_tail_idx == 4'd15) w_state_next = S_DONE;
      S_DONE:  if (out_ready) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_data   <= '0;
      r_cnt    <= '0;
      r_x      <= '0;
      r_result <= '0;
      r_out    <= '0;
      r_lfsr   <= LFSR_SEED;
    end else begin
      r_lfsr   <= {r_lfsr[19:0], r_lfsr[20] ^ r_lfsr[18]};
      r_result <= w_result_next;
      r_x      <= 4'd0;
      case (r_state)
        S_IDLE: if (in_valid) begin
          r_data <= w_in_x;
          r_cnt  <= 4'd0;
          r_x    <= w_in_x[3:0];
        end
        S_ISSUE: if (r_cnt != 4'd15) begin
          r_cnt <= w_cnt_inc;
          r_x   <= r_data[{w_cnt_inc, 2'b00} +: 4];
        end
        S_DRAIN: if (w_state_next == S_DONE) r_out <= p_layer(w_result_next);
        default: ;
      endcase
    end
  end

  // NOTE: the delay line is reset explicitly; leaving it unreset would let in-flight nibbles from before a reset land in the next result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dl_valid <= '0;
      for (int i = 0; i < SBOX_LAT; i++) r_dl_idx[i] <= 4'd0;
    end else begin
      r_dl_valid[0] <= (r_state == S_ISSUE);
      r_dl_idx[0]   <= r_cnt;
      for (int i = 1; i < SBOX_LAT; i++) begin
        r_dl_valid[i] <= r_dl_valid[i-1];
        r_dl_idx[i]   <= r_dl_idx[i-1];
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign out_state = r_out;
  assign sb_r      = r_lfsr;
  assign {sb_x3, sb_x2, sb_x1, sb_x0} = r_x;

endmodule

// File: doc/present_sbox_sequencer.md
PRESENT_SBOX_SEQUENCER -- requirements
Module: present_sbox_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: clk clocks everything; rst_n asynchronously resets when low.
REQ-002 The block SHALL have the following parameters (name, default, meaning):
- SBOX_LAT, 3: clock cycles from sb_x* change to the matching sb_y* value.
- LFSR_SEED, 21'h1B5E3: non-zero reset value of the randomness LFSR.
REQ-003 The block SHALL have the following ports (name, direction, width, meaning):
- clk  in  1  clock.
- rst_n  in  1  async active-low reset.
- in_valid  in  1  input state and key present.
- in_ready  out  1  block can accept an input.
- in_state  in  64  cipher state.
- in_key  in  64  round key.
- sb_x0, sb_x1, sb_x2, sb_x3  out  1 each  nibble to sbox; x0 = nibble bit 0, x3 = bit 3.
- sb_r  out  21  randomness to sbox.
- sb_y0, sb_y1, sb_y2, sb_y3  in  1 each  sbox result; y0 = bit 0, y3 = bit 3.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  64  round output after sLayer and pLayer.

Function
REQ-004 The FSM SHALL have the states IDLE, ISSUE, DRAIN and DONE; in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 In IDLE, when in_valid=1, the block SHALL register in_state^in_key, clear the issue counter and go to ISSUE; otherwise it SHALL stay in IDLE.
REQ-006 In ISSUE, in cycle k after the accept edge (k=1..16), sb_x* SHALL be registered outputs carrying nibble k-1 (bits 4(k-1)+3:4(k-1)) of the registered state.
REQ-007 The move from ISSUE to DRAIN SHALL happen after nibble 15 is issued; sb_x* SHALL be 0 whenever no nibble is being issued.
REQ-008 A SBOX_LAT-deep delay line of {valid, 4-bit index} SHALL track each issued nibble; sb_y* SHALL be written into result nibble idx when the tail of the line is valid, i.e. in cycle k+SBOX_LAT.
REQ-009 DRAIN SHALL go to DONE at the edge that captures nibble 15, which is cycle 16+SBOX_LAT (cycle 19 for the default).
REQ-010 out_state SHALL equal pLayer(result) and SHALL be registered on entry to DONE.
- pLayer: bit i moves to position (16*i) mod 63 for i<63; bit 63 stays at 63.
REQ-011 Latency: out_valid SHALL first be asserted in cycle 17+SBOX_LAT after the accept edge (cycle 20 for the default).
REQ-012 In DONE, out_valid and out_state SHALL hold stable until out_ready=1; the handshake edge SHALL return the FSM to IDLE, so in_ready=1 in the next cycle.
- There is no overlap: a new input is never accepted in the same cycle as the output handshake.
REQ-013 in_valid SHALL be ignored outside IDLE; changes on in_state and in_key after acceptance SHALL have no effect.
REQ-014 The LFSR SHALL be a 21-bit Fibonacci LFSR: next = {lfsr[19:0], lfsr[20]^lfsr[18]}.
- It advances every clock cycle after reset, in all states.
- sb_r = lfsr.
REQ-015 sb_y* values outside capture slots SHALL be ignored.

Reset
REQ-016 When rst_n=0, the block SHALL immediately force: FSM=IDLE, in_ready=1, out_valid=0, out_state=0, sb_x*=0, delay line cleared, result=0, lfsr=LFSR_SEED.
REQ-017 A reset in any state (including mid-ISSUE or mid-DRAIN) SHALL discard all in-flight nibbles; no stale capture SHALL occur after reset release.
REQ-018 After rst_n rises, the first clock edge SHALL be able to accept an input.

Verification
REQ-019 in_state=0, in_key=0, with a behavioural PRESENT sbox of latency 3 -> out_state=64'hFFFFFFFF00000000, out_valid in cycle 20 after accept.
REQ-020 in_state=64'hFFFFFFFFFFFFFFFF, in_key=0 -> out_state=64'h00000000FFFF0000.
REQ-021 in_state=in_key=64'h0123456789ABCDEF -> out_state=64'hFFFFFFFF00000000; sb_x* in cycles 1..16 equal 0 (nibbles cancel).
REQ-022 Hold out_ready=0 for 5 cycles in DONE -> out_state stable, in_ready=0, in_valid pulses ignored; out_ready=1 -> in_ready=1 in the next cycle.
REQ-023 Assert rst_n=0 in cycle 8 of ISSUE -> out_valid=0 and sb_x*=0 at once; a new zero-state run afterwards yields 64'hFFFFFFFF00000000.
REQ-024 After reset sb_r=21'h1B5E3; sb_r then follows REQ-014 each cycle and never reaches 0 over 2^21-1 cycles.
